weight_delta_encoder: RTL

//  Hardware producer of the delta-compressed weight stream that processing_unit consumes.

---
 rtl/weight_delta_encoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/weight_delta_encoder.sv
// Delta encoder for one channel of sorted weights: emits the base weight, then
// (delta, repeat-count) entries through a single valid/ready output register.
module weight_delta_encoder #(
    parameter int unsigned BIN_LEN       = 8,
    parameter int unsigned DELTA_LEN     = 4,
    parameter int unsigned DELTA_SIM_LEN = 4,
    parameter int unsigned CNT_LEN       = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BIN_LEN-1:0]       in_weight,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [BIN_LEN-1:0]       base_val,
    output logic                     base_valid,
    output logic [DELTA_LEN-1:0]     out_delta,
    output logic [DELTA_SIM_LEN-1:0] out_sim,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [CNT_LEN-1:0]       entry_count,
    output logic                     order_err,
    output logic                     done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OPEN  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [DELTA_SIM_LEN-1:0] SIM_MAX = '1;

    logic [1:0]               state, state_n;
    logic [BIN_LEN-1:0]       prev, prev_n;
    logic [DELTA_LEN-1:0]     cur_delta, cur_delta_n;
    logic [DELTA_SIM_LEN-1:0] cur_sim, cur_sim_n;
    logic [BIN_LEN-1:0]       base_val_n;
    logic                     base_valid_n;
    logic [DELTA_LEN-1:0]     out_delta_n;
    logic [DELTA_SIM_LEN-1:0] out_sim_n;
    logic                     out_valid_n, out_last_n;
    logic [CNT_LEN-1:0]       entry_count_n;
    logic                     order_err_n, done_n;

    logic                     accept, xfer, lower, same;
    logic [BIN_LEN-1:0]       diff;
    logic [DELTA_LEN-1:0]     dcode;

    // ceil(log2 d) for d >= 2: one above the top set bit of d-1
    function automatic logic [DELTA_LEN-1:0] delta_code(input logic [BIN_LEN-1:0] d);
        logic [BIN_LEN-1:0]   m;
        logic [DELTA_LEN-1:0] r;
        m = d - BIN_LEN'(1);
        r = '0;
        for (int i = 0; i < int'(BIN_LEN); i++) begin
            if (m[i]) r = DELTA_LEN'(i + 1);
        end
        if (d <= BIN_LEN'(1)) r = '0;
        return r;
    endfunction

    assign in_ready = (state != FLUSH) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign lower    = in_weight < prev;
    assign same     = in_weight == prev;
    assign diff     = in_weight - prev;
    assign dcode    = lower ? '0 : delta_code(diff);

    always_comb begin
        state_n       = state;
        prev_n        = prev;
        cur_delta_n   = cur_delta;
        cur_sim_n     = cur_sim;
        base_val_n    = base_val;
        base_valid_n  = 1'b0;
        out_delta_n   = out_delta;
        out_sim_n     = out_sim;
        out_valid_n   = out_valid;
        out_last_n    = out_last;
        entry_count_n = entry_count;
        order_err_n   = order_err;
        done_n        = 1'b0;

        if (xfer) begin
            out_valid_n   = 1'b0;
            out_last_n    = 1'b0;
            entry_count_n = entry_count + CNT_LEN'(1);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    base_val_n    = in_weight;
                    base_valid_n  = 1'b1;
                    prev_n        = in_weight;
                    entry_count_n = '0;
                    order_err_n   = 1'b0;
                    if (in_last) begin
                        cur_delta_n = '0;
                        cur_sim_n   = '0;
                        state_n     = FLUSH;
                    end else begin
                        state_n = OPEN;
                    end
                end
            end
            OPEN: begin
                if (accept) begin
                    order_err_n = order_err || lower;
                    cur_delta_n = dcode;
                    cur_sim_n   = DELTA_SIM_LEN'(1);
                    prev_n      = in_weight;
                    state_n     = in_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    order_err_n = order_err || lower;
                    prev_n      = in_weight;
                    if (same && cur_sim != SIM_MAX) begin
                        cur_sim_n = cur_sim + DELTA_SIM_LEN'(1);
                    end else begin
                        out_delta_n = cur_delta;
                        out_sim_n   = cur_sim;
                        out_valid_n = 1'b1;
                        out_last_n  = 1'b0;
                        cur_delta_n = same ? '0 : dcode;
                        cur_sim_n   = DELTA_SIM_LEN'(1);
                    end
                    if (in_last) state_n = FLUSH;
                end
            end
            FLUSH: begin
                // final entry already loaded: wait for its transfer
                if (out_valid && out_last) begin
                    if (out_ready) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else if (!out_valid || out_ready) begin
                    out_delta_n = cur_delta;
                    out_sim_n   = cur_sim;
                    out_valid_n = 1'b1;
                    out_last_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            prev        <= '0;
            cur_delta   <= '0;
            cur_sim     <= '0;
            base_val    <= '0;
            base_valid  <= 1'b0;
            out_delta   <= '0;
            out_sim     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            entry_count <= '0;
            order_err   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            prev        <= prev_n;
            cur_delta   <= cur_delta_n;
            cur_sim     <= cur_sim_n;
            base_val    <= base_val_n;
            base_valid  <= base_valid_n;
            out_delta   <= out_delta_n;
            out_sim     <= out_sim_n;
            out_valid   <= out_valid_n;
            out_last    <= out_last_n;
            entry_count <= entry_count_n;
            order_err   <= order_err_n;
            done        <= done_n;
        end
    end

endmodule
